// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, complex sample type and the
// state encoding used by the butterfly output serialiser.
package fft_pkg;

    localparam int BFLY_OUT_WIDTH = 11;
    localparam int FFT_LANES      = 16;

    typedef struct packed {
        logic signed [BFLY_OUT_WIDTH-1:0] re;
        logic signed [BFLY_OUT_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } bfly_ser_state_t;

endpackage

// File: rtl/bfly_half_buf.sv
// HALF x NUM complex storage holding the difference beats of one half-block.
// Synchronous write of a whole NUM-lane beat, combinational read of one beat.
module bfly_half_buf
    import fft_pkg::*;
#(
    parameter int WIDTH = BFLY_OUT_WIDTH,
    parameter int NUM   = FFT_LANES,
    parameter int HALF  = 8,
    parameter int AW    = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic signed [WIDTH-1:0] wdata_re [NUM],
    input  logic signed [WIDTH-1:0] wdata_im [NUM],
    input  logic [AW-1:0]           raddr,
    output logic signed [WIDTH-1:0] rdata_re [NUM],
    output logic signed [WIDTH-1:0] rdata_im [NUM]
);

    logic signed [WIDTH-1:0] mem_re_r [HALF][NUM];
    logic signed [WIDTH-1:0] mem_im_r [HALF][NUM];

    // Store one full beat into the addressed slot; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < NUM; l++) begin
                mem_re_r[waddr][l] <= wdata_re[l];
                mem_im_r[waddr][l] <= wdata_im[l];
            end
        end
    end

    // Present the addressed slot on the read port.
    always_comb begin
        for (int l = 0; l < NUM; l++) begin
            rdata_re[l] = mem_re_r[raddr][l];
            rdata_im[l] = mem_im_r[raddr][l];
        end
    end

endmodule

// File: rtl/bfly_dual_to_stream.sv
// Serialises the dual (sum/difference) butterfly output burst into one
// NUM-lane stream: HALF sum beats pass straight through while the difference
// beats are buffered, then the buffered beats are drained back to back.
module bfly_dual_to_stream
    import fft_pkg::*;
#(
    parameter int WIDTH = BFLY_OUT_WIDTH,
    parameter int NUM   = FFT_LANES,
    parameter int HALF  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] din1_re [NUM],
    input  logic signed [WIDTH-1:0] din1_im [NUM],
    input  logic signed [WIDTH-1:0] din2_re [NUM],
    input  logic signed [WIDTH-1:0] din2_im [NUM],
    output logic signed [WIDTH-1:0] dout_re [NUM],
    output logic signed [WIDTH-1:0] dout_im [NUM],
    output logic                    valid_out,
    output logic                    sof_out,
    output logic                    eof_out,
    output logic                    overflow
);

    localparam int AW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(HALF - 1);

    bfly_ser_state_t         state_r, state_s;
    logic [AW-1:0]           wr_cnt_r, wr_cnt_s;
    logic [AW-1:0]           rd_cnt_r, rd_cnt_s;
    logic                    valid_r, valid_s;
    logic                    sof_r, sof_s;
    logic                    eof_r, eof_s;
    logic                    ovf_r, ovf_s;
    logic signed [WIDTH-1:0] dout_re_r [NUM];
    logic signed [WIDTH-1:0] dout_im_r [NUM];
    logic signed [WIDTH-1:0] dout_re_s [NUM];
    logic signed [WIDTH-1:0] dout_im_s [NUM];
    logic                    we_s;
    logic [AW-1:0]           waddr_s;
    logic signed [WIDTH-1:0] buf_re_s [NUM];
    logic signed [WIDTH-1:0] buf_im_s [NUM];

    bfly_half_buf #(
        .WIDTH (WIDTH),
        .NUM   (NUM),
        .HALF  (HALF),
        .AW    (AW)
    ) u_half_buf (
        .clk      (clk),
        .we       (we_s),
        .waddr    (waddr_s),
        .wdata_re (din2_re),
        .wdata_im (din2_im),
        .raddr    (rd_cnt_r),
        .rdata_re (buf_re_s),
        .rdata_im (buf_im_s)
    );

    // Next-state, counter, buffer-write and next-output decode.
    always_comb begin
        state_s  = state_r;
        wr_cnt_s = wr_cnt_r;
        rd_cnt_s = rd_cnt_r;
        valid_s  = 1'b0;
        sof_s    = 1'b0;
        eof_s    = 1'b0;
        ovf_s    = ovf_r;
        we_s     = 1'b0;
        waddr_s  = wr_cnt_r;
        for (int l = 0; l < NUM; l++) begin
            dout_re_s[l] = dout_re_r[l];
            dout_im_s[l] = dout_im_r[l];
        end

        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    for (int l = 0; l < NUM; l++) begin
                        dout_re_s[l] = din1_re[l];
                        dout_im_s[l] = din1_im[l];
                    end
                    valid_s  = 1'b1;
                    sof_s    = 1'b1;
                    we_s     = 1'b1;
                    waddr_s  = {AW{1'b0}};
                    rd_cnt_s = {AW{1'b0}};
                    if (HALF == 1) begin
                        wr_cnt_s = {AW{1'b0}};
                        state_s  = DRAIN;
                    end else begin
                        wr_cnt_s = AW'(1);
                        state_s  = FILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (valid_in) begin
                    for (int l = 0; l < NUM; l++) begin
                        dout_re_s[l] = din1_re[l];
                        dout_im_s[l] = din1_im[l];
                    end
                    valid_s = 1'b1;
                    we_s    = 1'b1;
                    if (wr_cnt_r == LAST_IDX) begin
                        wr_cnt_s = {AW{1'b0}};
                        rd_cnt_s = {AW{1'b0}};
                        state_s  = DRAIN;
                    end else begin
                        wr_cnt_s = wr_cnt_r + AW'(1);
                    end
                end else begin
                    state_s = FILL;
                end
            end
            DRAIN: begin
                for (int l = 0; l < NUM; l++) begin
                    dout_re_s[l] = buf_re_s[l];
                    dout_im_s[l] = buf_im_s[l];
                end
                valid_s = 1'b1;
                // No room to accept input while draining: drop and flag it.
                if (valid_in) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_r;
                end
                if (rd_cnt_r == LAST_IDX) begin
                    eof_s    = 1'b1;
                    rd_cnt_s = {AW{1'b0}};
                    state_s  = IDLE;
                end else begin
                    rd_cnt_s = rd_cnt_r + AW'(1);
                end
            end
            default: begin
                state_s  = IDLE;
                wr_cnt_s = {AW{1'b0}};
                rd_cnt_s = {AW{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            wr_cnt_r <= {AW{1'b0}};
            rd_cnt_r <= {AW{1'b0}};
            valid_r  <= 1'b0;
            sof_r    <= 1'b0;
            eof_r    <= 1'b0;
            ovf_r    <= 1'b0;
            for (int l = 0; l < NUM; l++) begin
                dout_re_r[l] <= {WIDTH{1'b0}};
                dout_im_r[l] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r  <= state_s;
            wr_cnt_r <= wr_cnt_s;
            rd_cnt_r <= rd_cnt_s;
            valid_r  <= valid_s;
            sof_r    <= sof_s;
            eof_r    <= eof_s;
            ovf_r    <= ovf_s;
            for (int l = 0; l < NUM; l++) begin
                dout_re_r[l] <= dout_re_s[l];
                dout_im_r[l] <= dout_im_s[l];
            end
        end
    end

    assign dout_re   = dout_re_r;
    assign dout_im   = dout_im_r;
    assign valid_out = valid_r;
    assign sof_out   = sof_r;
    assign eof_out   = eof_r;
    assign overflow  = ovf_r;

endmodule

// File: doc/bfly_dual_to_stream.md
Name: bfly_dual_to_stream

Overview:
- Output-side companion of the first-stage DIF butterfly.
- The butterfly emits sum (do1) and difference (do2) vectors together, NUM lanes each, for HALF consecutive beats.
- This block turns that dual-output burst back into a single NUM-lane stream for the next FFT stage.
- Stream order: all HALF sum beats first, then all HALF buffered difference beats.

Parameters:
- WIDTH, 11, signed bit width of each real/imag sample (butterfly output width).
- NUM, 16, number of parallel lanes.
- HALF, 8, beats per half-block (sum beats, and equally difference beats).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  din1/din2 lanes valid this cycle.
- din1_re  input  signed [WIDTH-1:0] x NUM  sum output, real.
- din1_im  input  signed [WIDTH-1:0] x NUM  sum output, imag.
- din2_re  input  signed [WIDTH-1:0] x NUM  difference output, real.
- din2_im  input  signed [WIDTH-1:0] x NUM  difference output, imag.
- dout_re  output  signed [WIDTH-1:0] x NUM  stream output, real.
- dout_im  output  signed [WIDTH-1:0] x NUM  stream output, imag.
- valid_out  output  1  dout valid.
- sof_out  output  1  first beat of a 2*HALF-beat frame.
- eof_out  output  1  last beat of a frame.
- overflow  output  1  sticky: a valid_in beat was dropped.

Behaviour:
- Reset values: dout_re/dout_im all 0, valid_out/sof_out/eof_out/overflow 0, state IDLE, both counters 0. Reset takes effect immediately at any time, including mid-frame. Any partial frame is discarded and not resumed.
- All outputs are registered. Latency from a din1 beat to the same data on dout is 1 cycle.
- States:
  - IDLE: waiting for data.
  - FILL: wr_cnt counts 0..HALF-1 over accepted beats.
  - DRAIN: rd_cnt counts 0..HALF-1, one beat per cycle.
- IDLE, valid_in=1: dout <= din1, valid_out <= 1, sof_out <= 1. din2 written to buffer slot 0. wr_cnt <= 1. Go to FILL; if HALF==1, go straight to DRAIN.
- FILL, valid_in=1: dout <= din1, valid_out <= 1. din2 written to slot wr_cnt. wr_cnt increments. On the HALF-th beat, go to DRAIN with rd_cnt=0.
- FILL, valid_in=0 (gap): valid_out <= 0, dout holds its last value, counters hold. Gaps of any length are legal.
- DRAIN: one beat every cycle, independent of valid_in. dout <= buffer[rd_cnt], valid_out <= 1, rd_cnt increments. eof_out <= 1 on rd_cnt==HALF-1, then go to IDLE.
- With contiguous input, the output is a gap-free stream of 2*HALF beats.
- valid_in=1 during DRAIN: the beat is dropped and overflow <= 1. overflow stays set until rst.
- Sum and difference values pass through bit-exact: no arithmetic, rounding or saturation.
- Buffer ordering: difference beat k is output exactly HALF beats after sum beat k, in the same lane.
- A valid_in arriving in the same cycle as the final DRAIN beat is dropped and flagged, because the state is still DRAIN. A new frame can only start from IDLE.
- sof_out and eof_out are single-cycle pulses and are only ever high together with valid_out.

Decomposition:
- Shared package fft_pkg holds:
  - the cplx_t struct {re, im} parameterised by width via localparams;
  - the state enum bfly_ser_state_t {IDLE, FILL, DRAIN};
  - the defaults BFLY_OUT_WIDTH=11, FFT_LANES=16.
- One sub-module, bfly_half_buf: HALF x NUM complex register storage with a synchronous write port (we, waddr) and a combinational read port (raddr). No reset is needed on its storage.

Test Plan (NUM=16, WIDTH=11, HALF=8):
- Contiguous frame: 8 beats, lane L of beat k has din1=(k*16+L, -k) and din2=(100+k, 200+L). Expect 16 consecutive valid_out beats starting 1 cycle after the first input. Beats 0-7 carry din1, beats 8-15 carry din2. sof_out on beat 0, eof_out on beat 15.
- Sign extremes: din1=(-1024, 1023), din2=(1023, -1024) on all lanes. Expect identical values on dout, with no sign or width corruption.
- Gapped fill: valid_in pattern 1,0,0,1,1,0,1,1,1,1,1. Expect valid_out to mirror the pattern delayed 1 cycle. DRAIN's 8 beats follow immediately after the 8th accepted beat.
- Overflow: assert valid_in on the 3rd DRAIN cycle. Expect that beat dropped, overflow=1 and held. DRAIN output unaffected. The next frame from IDLE is processed correctly with overflow still 1.
- Reset mid-frame: pulse rst during FILL beat 5. Expect all outputs 0 asynchronously. A following full frame starts with sof_out and yields a correct 16-beat stream.
- Back-to-back: a second frame starts in the first cycle after eof_out. Expect two correct frames with no overflow.
